// File: rtl/menu_pkg.sv
// menu_pkg
//   Shared definitions for the menu responder: page codes, FSM state codes,
//   error-menu option indices, default option counts and the cursor step
//   helper.
//   Build option: MENU_WRAP_EN -- when defined the cursor wraps at both range
//   ends; when undefined it saturates at 0 and at max.
package menu_pkg;

    // Page codes carried on menu_sel[1:0]
    localparam logic [1:0] PAG_MODO   = 2'd0;
    localparam logic [1:0] PAG_BPM    = 2'd1;
    localparam logic [1:0] PAG_TOM    = 2'd2;
    localparam logic [1:0] PAG_MUSICA = 2'd3;

    // FSM state codes; the encoding doubles as the debug state output
    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        NAVEGA      = 3'd1,
        NAVEGA_ERRO = 3'd2,
        CONFIRMA    = 3'd3
    } estado_t;

    // Error-menu options, bit positions of the erros one-hot
    typedef enum logic [1:0] {
        ERRO_APRESENTA_ULTIMA = 2'd0,
        ERRO_TENTAR_DNV       = 2'd1,
        ERRO_TENTAR_DNV_REP   = 2'd2
    } erro_op_t;

    localparam logic [3:0] ERRO_MAX = 4'(ERRO_TENTAR_DNV_REP);

    // Default option counts
    localparam int N_MODOS          = 4;
    localparam int N_BPM_PADRAO     = 4;
    localparam int N_TOM_PADRAO     = 12;
    localparam int N_MUSICAS_PADRAO = 16;

    // Index of the set bit in a 4-bit one-hot (0 for a malformed value)
    function automatic logic [1:0] indice_onehot(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // One cursor step up (sobe=1) or down (sobe=0) inside 0..max
    function automatic logic [3:0] passo_cursor(input logic [3:0] cur,
                                                input logic [3:0] max,
                                                input logic       sobe);
        logic [3:0] prox;
        if (sobe) begin
`ifdef MENU_WRAP_EN
            prox = (cur >= max) ? 4'd0 : cur + 4'd1;
`else
            prox = (cur >= max) ? max : cur + 4'd1;
`endif
        end else begin
`ifdef MENU_WRAP_EN
            prox = (cur == 4'd0) ? max : cur - 4'd1;
`else
            prox = (cur == 4'd0) ? 4'd0 : cur - 4'd1;
`endif
        end
        return prox;
    endfunction

endpackage

// File: rtl/menu_detector_borda.sv
// menu_detector_borda
//   1-bit rising-edge detector. borda is high in the cycle where nivel is 1
//   and was 0 in the previous cycle.
//   Ports: clock, reset (sync, active-high), nivel (input level),
//          borda (edge pulse, combinational from nivel and the stored level)
module menu_detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic nivel,
    output logic borda
);

    logic anterior;

    always_ff @(posedge clock) begin
        if (reset) anterior <= 1'b0;
        else       anterior <= nivel;
    end

    assign borda = nivel & ~anterior;

endmodule

// File: rtl/menu_respondedor.sv
// menu_respondedor
//   Responder side of the menu handshake. Opens on inicia_menu, navigates a
//   cursor with the up/down buttons and, on an enter edge, commits the cursor
//   to the selected page register and returns a one-cycle press_enter.
//   Build option: MENU_WRAP_EN (cursor wraps instead of saturating).
//   Ports:
//     clock, reset          single clock, synchronous active-high reset
//     inicia_menu           open/restart pulse
//     menu_sel[2:0]         page select, bit2 flags a pending error menu
//     botao_cima/baixo/enter debounced button levels
//     press_enter           confirm pulse
//     modos, bpm, tom, musica, erros  committed selections
//     cursor                highlighted option
//     menu_ativo            menu open
//     db_estado             current FSM state code
module menu_respondedor
    import menu_pkg::*;
#(
    parameter int N_BPM     = N_BPM_PADRAO,
    parameter int N_TOM     = N_TOM_PADRAO,
    parameter int N_MUSICAS = N_MUSICAS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inicia_menu,
    input  logic [2:0] menu_sel,
    input  logic       botao_cima,
    input  logic       botao_baixo,
    input  logic       botao_enter,
    output logic       press_enter,
    output logic [3:0] modos,
    output logic [1:0] bpm,
    output logic [3:0] tom,
    output logic [3:0] musica,
    output logic [2:0] erros,
    output logic [3:0] cursor,
    output logic       menu_ativo,
    output logic [2:0] db_estado
);

    localparam logic [3:0] MAX_MODO   = 4'(N_MODOS - 1);
    localparam logic [3:0] MAX_BPM    = 4'(N_BPM - 1);
    localparam logic [3:0] MAX_TOM    = 4'(N_TOM - 1);
    localparam logic [3:0] MAX_MUSICA = 4'(N_MUSICAS - 1);

    estado_t    estado;
    logic [1:0] pagina;      // page the cursor currently belongs to
    logic       em_erro;     // navigating / confirming the error menu
    logic       latch_erro;  // error menu requested, waiting for inicia_menu

    logic borda_cima, borda_baixo, borda_enter;
    logic [3:0] valor_pagina;
    logic [3:0] max_cursor;

    menu_detector_borda u_borda_cima (
        .clock (clock), .reset (reset), .nivel (botao_cima),  .borda (borda_cima)
    );
    menu_detector_borda u_borda_baixo (
        .clock (clock), .reset (reset), .nivel (botao_baixo), .borda (borda_baixo)
    );
    menu_detector_borda u_borda_enter (
        .clock (clock), .reset (reset), .nivel (botao_enter), .borda (borda_enter)
    );

    // Committed value of the page requested on menu_sel; the cursor reloads
    // from it on menu open and on every page change.
    always_comb begin
        valor_pagina = 4'd0;
        case (menu_sel[1:0])
            PAG_MODO:   valor_pagina = {2'b00, indice_onehot(modos)};
            PAG_BPM:    valor_pagina = {2'b00, bpm};
            PAG_TOM:    valor_pagina = tom;
            PAG_MUSICA: valor_pagina = musica;
            default:    valor_pagina = 4'd0;
        endcase
    end

    always_comb begin
        max_cursor = MAX_MODO;
        if (em_erro) begin
            max_cursor = ERRO_MAX;
        end else begin
            case (pagina)
                PAG_MODO:   max_cursor = MAX_MODO;
                PAG_BPM:    max_cursor = MAX_BPM;
                PAG_TOM:    max_cursor = MAX_TOM;
                PAG_MUSICA: max_cursor = MAX_MUSICA;
                default:    max_cursor = MAX_MODO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            pagina      <= PAG_MODO;
            em_erro     <= 1'b0;
            latch_erro  <= 1'b0;
            press_enter <= 1'b0;
            cursor      <= 4'd0;
            modos       <= 4'b0001;
            bpm         <= 2'd0;
            tom         <= 4'd0;
            musica      <= 4'd0;
            erros       <= 3'b000;
        end else begin
            press_enter <= 1'b0;

            // inicia_menu overrides everything, including same-cycle edges
            if (inicia_menu) begin
                em_erro <= latch_erro;
                if (latch_erro) begin
                    estado     <= NAVEGA_ERRO;
                    latch_erro <= 1'b0;
                    erros      <= 3'b000;
                    cursor     <= 4'd0;
                end else begin
                    estado <= NAVEGA;
                    pagina <= menu_sel[1:0];
                    cursor <= valor_pagina;
                end
            end else begin
                case (estado)
                    OCIOSO: begin
                    end

                    NAVEGA: begin
                        // A page change takes the whole cycle; edges are dropped
                        if (menu_sel[1:0] != pagina) begin
                            pagina <= menu_sel[1:0];
                            cursor <= valor_pagina;
                        end else if (borda_enter) begin
                            estado      <= CONFIRMA;
                            press_enter <= 1'b1;
                            case (pagina)
                                PAG_MODO:   modos  <= 4'b0001 << cursor[1:0];
                                PAG_BPM:    bpm    <= cursor[1:0];
                                PAG_TOM:    tom    <= cursor;
                                PAG_MUSICA: musica <= cursor;
                                default:    modos  <= 4'b0001;
                            endcase
                        end else if (borda_cima != borda_baixo) begin
                            cursor <= passo_cursor(cursor, max_cursor, borda_cima);
                        end
                    end

                    NAVEGA_ERRO: begin
                        if (borda_enter) begin
                            estado      <= CONFIRMA;
                            press_enter <= 1'b1;
                            erros       <= 3'b001 << cursor[1:0];
                        end else if (borda_cima != borda_baixo) begin
                            cursor <= passo_cursor(cursor, max_cursor, borda_cima);
                        end
                    end

                    CONFIRMA: begin
                        if (em_erro || pagina == PAG_MUSICA) estado <= OCIOSO;
                        else                                 estado <= NAVEGA;
                        em_erro <= 1'b0;
                    end

                    default: estado <= OCIOSO;
                endcase
            end

            // A request seen in any cycle is kept for the next menu open
            if (menu_sel[2]) latch_erro <= 1'b1;
        end
    end

    assign menu_ativo = (estado != OCIOSO);
    assign db_estado  = estado;

endmodule
